dmux_stream: RTL and testbench
==============================

# dmux_stream

Parametrised, registered stream demultiplexer: routes each accepted WIDTH-bit word to one of CH output channels chosen by a per-word select, using valid/ready handshakes on input and every output. It generalises the fixed 1-bit, 8-way combinational demux to arbitrary width and channel count, and adds flow control and one output buffer stage. It sits between the CPU/memory-mapped write path and multiple peripheral sinks (screen, keyboard, LED/UART ports) on the Tang Primer 20K build.

## Interface

Parameters:
- WIDTH, 16, data word width in bits (≥1).
- CH, 8, number of output channels (2..64; need not be a power of two).
- SEL_W, $clog2(CH), select width; derived and must not be overridden.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  CH  one-hot (or zero) per-channel valid.
- out_ready  input  CH  per-channel sink ready.
- out_data  output  WIDTH  buffered word, shared by all channels.
- sel_err  output  1  sticky flag: a word with in_sel ≥ CH was dropped.
- err_clr  input  1  synchronous clear of sel_err.

## Operation

- One holding register (data, sel) with two states: EMPTY and FULL.
- Input transfer: in_valid && in_ready on a rising edge.
- Output transfer on channel k: out_valid[k] && out_ready[k].
- in_ready = EMPTY, or FULL && out_ready[held_sel].
  - Combinational pass-through of the held channel's ready gives one word per cycle when the sink is always ready.
  - Sinks must not make out_ready depend on in_valid.
- out_valid[k] = FULL && held_sel == k. At most one bit is set. out_data = held data, and is only meaningful while FULL.
- Transitions:
  - EMPTY + input transfer with legal sel → FULL; the word and sel are latched.
  - FULL + output transfer, no input → EMPTY.
  - FULL + output transfer + input transfer in the same cycle → stays FULL with the new word. No bubble and no loss.
  - FULL with no output transfer → holds. data and sel stay stable (AXI-style valid stability).
- Illegal sel (in_sel ≥ CH, only possible when CH is not a power of two):
  - The word is still accepted (in_ready as above) and then discarded. The register state is unchanged by it.
  - sel_err is set on the next edge.
- sel_err: cleared by err_clr. When set and clear happen in the same cycle, set wins.
- in_sel is ignored while in_valid = 0.

## Timing

- Reset (asynchronous, rst_n low): state = EMPTY, out_valid = 0, out_data = 0, sel_err = 0. in_ready reads 1 during and after reset. Release is synchronous to clk.
- Reset asserted mid-operation: the held word is discarded immediately and out_valid drops to 0 without waiting for a clock edge.
- Latency: a word accepted at edge n appears on out_valid/out_data immediately after edge n, so it is seen at edge n+1. This is one cycle of latency.
- Throughput: one word per cycle while the destination sink is ready. Consecutive words may target different channels with no penalty.
- Backpressure: while the held channel's sink is not ready, in_ready = 0, whatever the other channels' ready lines are (head-of-line blocking is accepted).

## Configuration

- DMUX_STREAM_CNT_EN:
  - Defined: adds output port drop_cnt [7:0], a saturating count of words dropped for illegal sel. It resets to 0, clears on err_clr, and holds at 255. When an increment and err_clr occur in the same cycle, the result is 1.
  - Undefined: the port and its counter do not exist. sel_err behaviour is identical in both builds.

## Test plan

- Reset: rst_n=0 while FULL holding 0x1234 on ch3 → out_valid=0 and out_data=0 asynchronously, in_ready=1. After release, the first word is accepted.
- Streaming: CH=8, WIDTH=16, all out_ready=1, send 0x0001..0x0008 to sel 0..7 on back-to-back cycles → out_valid[k] is one-hot with data 0x000(k+1) in consecutive cycles, and in_ready stays 1.
- Backpressure: send 0xBEEF to ch5 with out_ready[5]=0 for 4 cycles and the other readys at 1 → in_ready=0, out_data=0xBEEF is stable, out_valid=8'b0010_0000. Set out_ready[5]=1 with the next word 0xCAFE to ch2 → both transfer in one cycle, and the next cycle shows out_valid[2]=1 with 0xCAFE.
- Illegal sel: CH=6, send sel=7 with data 0xDEAD → no out_valid, sel_err=1 on the next cycle. err_clr together with a second illegal word → sel_err stays 1.
- Counter (DMUX_STREAM_CNT_EN): 300 illegal words → drop_cnt saturates at 255. err_clr → 0.
- Width/odd channels: WIDTH=1, CH=3, random valid/ready stimulus against a scoreboard model → no word lost, duplicated or misrouted, and out_valid is never more than one-hot.

Source files
------------

// File: rtl/dmux_stream.sv
// dmux_stream: registered valid/ready stream demultiplexer.
// Each accepted WIDTH-bit word goes to one of CH channels chosen by in_sel.
// A single holding register provides the output buffer stage. The held
// channel's ready is passed straight through to in_ready, so a sink that is
// always ready receives one word per cycle.
// Words with in_sel >= CH are accepted, discarded and flagged in sel_err.
// Optional build macro: DMUX_STREAM_CNT_EN adds drop_cnt[7:0], a saturating
// count of words dropped for an illegal select.

module dmux_stream #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CH    = 8,
   // Derived from CH; do not override.
   parameter int unsigned SEL_W = $clog2(CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] in_sel,
   output logic [CH-1:0]    out_valid,
   input  logic [CH-1:0]    out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             sel_err,
`ifdef DMUX_STREAM_CNT_EN
   output logic [7:0]       drop_cnt,
`endif
   input  logic             err_clr
);

   // One extra bit so that CH itself is representable, even when CH is a
   // power of two.
   localparam logic [SEL_W:0] ChLimit = (SEL_W + 1)'(CH);

   typedef enum logic {
      StEmpty,
      StFull
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   // One-hot copy of the held select; doubles as the registered out_valid.
   logic [CH-1:0]    r_out_valid;
   logic             r_sel_err;

   logic             w_sel_legal;
   logic [CH-1:0]    w_dec;
   logic             w_out_xfer;
   logic             w_in_xfer;
   logic             w_load;
   logic             w_drop;

   // Select decode and handshake qualification
   always_comb begin
      w_sel_legal = ({1'b0, in_sel} < ChLimit);
      // An illegal select shifts the bit out; the result is then unused.
      w_dec       = CH'(1) << in_sel;
      // r_out_valid is zero while empty, so this is the held channel's ready.
      w_out_xfer  = |(r_out_valid & out_ready);
      in_ready    = (r_state == StEmpty) || w_out_xfer;
      w_in_xfer   = in_valid && in_ready;
      w_load      = w_in_xfer && w_sel_legal;
      w_drop      = w_in_xfer && !w_sel_legal;
   end

   // Holding-register FSM: EMPTY/FULL with registered data and one-hot valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StEmpty;
         r_data      <= '0;
         r_out_valid <= '0;
      end else begin
         unique case (r_state)
            StEmpty: begin
               if (w_load) begin
                  r_state     <= StFull;
                  r_data      <= in_data;
                  r_out_valid <= w_dec;
               end
            end
            StFull: begin
               if (w_out_xfer) begin
                  if (w_load) begin
                     // Simultaneous drain and refill: no bubble.
                     r_data      <= in_data;
                     r_out_valid <= w_dec;
                  end else begin
                     // Includes the case of an illegal word arriving while
                     // draining: it is dropped and the register empties.
                     r_state     <= StEmpty;
                     r_out_valid <= '0;
                  end
               end
            end
            default: begin
               r_state     <= StEmpty;
               r_out_valid <= '0;
            end
         endcase
      end
   end

   // Sticky illegal-select flag; a new drop wins over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_err <= 1'b0;
      end else if (w_drop) begin
         r_sel_err <= 1'b1;
      end else if (err_clr) begin
         r_sel_err <= 1'b0;
      end
   end

`ifdef DMUX_STREAM_CNT_EN
   logic [7:0] r_drop_cnt;

   // Saturating drop counter; a clear together with a drop restarts at 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         if (err_clr) begin
            r_drop_cnt <= 8'd1;
         end else if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end else if (err_clr) begin
         r_drop_cnt <= '0;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign out_valid = r_out_valid;
   assign out_data  = r_data;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: three instances (16x8, 16x6 and 1x3) with a
// per-instance scoreboard queue filled on input transfers and drained on
// output transfers, plus directed checks of reset, latency, backpressure
// and illegal-select handling. Build with DMUX_STREAM_CNT_EN to cover drop_cnt.

module tb_dmux_stream;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // ---------------- instance A: WIDTH=16, CH=8
   logic        a_in_valid, a_in_ready, a_sel_err, a_err_clr;
   logic [15:0] a_in_data, a_out_data;
   logic [2:0]  a_in_sel;
   logic [7:0]  a_out_valid, a_out_ready;
`ifdef DMUX_STREAM_CNT_EN
   logic [7:0]  a_drop_cnt;
`endif

   dmux_stream #(.WIDTH(16), .CH(8)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .in_sel    (a_in_sel),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .sel_err   (a_sel_err),
`ifdef DMUX_STREAM_CNT_EN
      .drop_cnt  (a_drop_cnt),
`endif
      .err_clr   (a_err_clr)
   );

   // ---------------- instance B: WIDTH=16, CH=6
   logic        b_in_valid, b_in_ready, b_sel_err, b_err_clr;
   logic [15:0] b_in_data, b_out_data;
   logic [2:0]  b_in_sel;
   logic [5:0]  b_out_valid, b_out_ready;
`ifdef DMUX_STREAM_CNT_EN
   logic [7:0]  b_drop_cnt;
`endif

   dmux_stream #(.WIDTH(16), .CH(6)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .in_sel    (b_in_sel),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .sel_err   (b_sel_err),
`ifdef DMUX_STREAM_CNT_EN
      .drop_cnt  (b_drop_cnt),
`endif
      .err_clr   (b_err_clr)
   );

   // ---------------- instance C: WIDTH=1, CH=3
   logic       c_in_valid, c_in_ready, c_sel_err, c_err_clr;
   logic [0:0] c_in_data, c_out_data;
   logic [1:0] c_in_sel;
   logic [2:0] c_out_valid, c_out_ready;
`ifdef DMUX_STREAM_CNT_EN
   logic [7:0] c_drop_cnt;
`endif

   dmux_stream #(.WIDTH(1), .CH(3)) u_dut_c (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (c_in_valid),
      .in_ready  (c_in_ready),
      .in_data   (c_in_data),
      .in_sel    (c_in_sel),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out_data  (c_out_data),
      .sel_err   (c_sel_err),
`ifdef DMUX_STREAM_CNT_EN
      .drop_cnt  (c_drop_cnt),
`endif
      .err_clr   (c_err_clr)
   );

   // Single comparison point for every check in the bench
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboards: entry = {channel, data}
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] q_c[$];

   always @(negedge rst_n) begin
      q_a.delete();
      q_b.delete();
      q_c.delete();
   end

   // Monitors sample at negedge; the handshakes seen here complete at the next posedge
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n) begin
         // Instance A
         check("a_onehot", 64'($countones(a_out_valid) <= 1), 64'd1);
         if (|(a_out_valid & a_out_ready)) begin
            if (q_a.size() == 0) check("a_spurious", 64'd1, 64'd0);
            else begin
               e = q_a.pop_front();
               check("a_data", 64'(a_out_data), 64'(e[15:0]));
               check("a_route", 64'(a_out_valid), 64'(1) << e[23:16]);
            end
         end
         if (a_in_valid && a_in_ready) q_a.push_back({8'(a_in_sel), a_in_data});
         // Instance B (CH=6: selects 6 and 7 are illegal)
         check("b_onehot", 64'($countones(b_out_valid) <= 1), 64'd1);
         if (|(b_out_valid & b_out_ready)) begin
            if (q_b.size() == 0) check("b_spurious", 64'd1, 64'd0);
            else begin
               e = q_b.pop_front();
               check("b_data", 64'(b_out_data), 64'(e[15:0]));
               check("b_route", 64'(b_out_valid), 64'(1) << e[23:16]);
            end
         end
         if (b_in_valid && b_in_ready && b_in_sel < 3'd6) q_b.push_back({8'(b_in_sel), b_in_data});
         // Instance C (CH=3: select 3 is illegal)
         check("c_onehot", 64'($countones(c_out_valid) <= 1), 64'd1);
         if (|(c_out_valid & c_out_ready)) begin
            if (q_c.size() == 0) check("c_spurious", 64'd1, 64'd0);
            else begin
               e = q_c.pop_front();
               check("c_data", 64'(c_out_data), 64'(e[15:0]));
               check("c_route", 64'(c_out_valid), 64'(1) << e[23:16]);
            end
         end
         if (c_in_valid && c_in_ready && c_in_sel < 2'd3) q_c.push_back({8'(c_in_sel), 15'd0, c_in_data});
      end
   end

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_in_valid = 0; a_in_data = '0; a_in_sel = '0; a_out_ready = '0; a_err_clr = 0;
      b_in_valid = 0; b_in_data = '0; b_in_sel = '0; b_out_ready = '0; b_err_clr = 0;
      c_in_valid = 0; c_in_data = '0; c_in_sel = '0; c_out_ready = '0; c_err_clr = 0;

      // Reset state, before any clock edge
      #3;
      check("rst_in_ready", 64'(a_in_ready), 64'd1);
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_out_data", 64'(a_out_data), 64'd0);
      check("rst_sel_err", 64'(a_sel_err), 64'd0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // Load 0x1234 on ch3 with its sink stalled, then reset asynchronously
      a_out_ready = 8'hF7;
      a_in_valid = 1; a_in_data = 16'h1234; a_in_sel = 3'd3;
      cyc();
      a_in_valid = 0;
      @(negedge clk);
      check("full_valid", 64'(a_out_valid), 64'h08);
      check("full_data", 64'(a_out_data), 64'h1234);
      check("full_in_ready", 64'(a_in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 64'(a_out_valid), 64'd0);
      check("async_data", 64'(a_out_data), 64'd0);
      check("async_in_ready", 64'(a_in_ready), 64'd1);
      cyc();
      rst_n = 1'b1;

      // First word after release is accepted
      a_out_ready = 8'hFF;
      a_in_valid = 1; a_in_data = 16'h5555; a_in_sel = 3'd1;
      @(negedge clk);
      check("rel_in_ready", 64'(a_in_ready), 64'd1);
      cyc();
      a_in_valid = 0;
      @(negedge clk);
      check("rel_valid", 64'(a_out_valid), 64'h02);
      check("rel_data", 64'(a_out_data), 64'h5555);
      cyc();

      // Back-to-back streaming over all eight channels
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1; a_in_data = 16'(i + 1); a_in_sel = 3'(i);
         @(negedge clk);
         check("stream_in_ready", 64'(a_in_ready), 64'd1);
         if (i > 0) begin
            check("stream_valid", 64'(a_out_valid), 64'(1) << (i - 1));
            check("stream_data", 64'(a_out_data), 64'(i));
         end
         cyc();
      end
      a_in_valid = 0;
      @(negedge clk);
      check("stream_last_valid", 64'(a_out_valid), 64'h80);
      check("stream_last_data", 64'(a_out_data), 64'h0008);
      cyc();

      // Backpressure on ch5 while every other sink is ready
      a_out_ready = 8'hDF;
      a_in_valid = 1; a_in_data = 16'hBEEF; a_in_sel = 3'd5;
      cyc();
      a_in_data = 16'hCAFE; a_in_sel = 3'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(a_in_ready), 64'd0);
         check("bp_valid", 64'(a_out_valid), 64'h20);
         check("bp_data", 64'(a_out_data), 64'hBEEF);
         cyc();
      end
      a_out_ready = 8'hFF;
      @(negedge clk);
      check("bp_release_in_ready", 64'(a_in_ready), 64'd1);
      cyc();
      a_in_valid = 0;
      @(negedge clk);
      check("bp_next_valid", 64'(a_out_valid), 64'h04);
      check("bp_next_data", 64'(a_out_data), 64'hCAFE);
      cyc();

      // Illegal select on the CH=6 instance
      b_out_ready = 6'h3F;
      b_in_valid = 1; b_in_data = 16'hDEAD; b_in_sel = 3'd7;
      @(negedge clk);
      check("ill_in_ready", 64'(b_in_ready), 64'd1);
      check("ill_err_before", 64'(b_sel_err), 64'd0);
      cyc();
      b_in_valid = 0;
      @(negedge clk);
      check("ill_no_valid", 64'(b_out_valid), 64'd0);
      check("ill_err_set", 64'(b_sel_err), 64'd1);
`ifdef DMUX_STREAM_CNT_EN
      check("cnt_one", 64'(b_drop_cnt), 64'd1);
`endif
      cyc();
      // Clear together with a second illegal word: set wins
      b_in_valid = 1; b_in_sel = 3'd6; b_err_clr = 1;
      cyc();
      b_in_valid = 0; b_err_clr = 0;
      @(negedge clk);
      check("ill_set_wins", 64'(b_sel_err), 64'd1);
      check("ill_no_valid2", 64'(b_out_valid), 64'd0);
`ifdef DMUX_STREAM_CNT_EN
      check("cnt_clr_inc", 64'(b_drop_cnt), 64'd1);
`endif
      cyc();
      b_err_clr = 1;
      cyc();
      b_err_clr = 0;
      @(negedge clk);
      check("ill_cleared", 64'(b_sel_err), 64'd0);
`ifdef DMUX_STREAM_CNT_EN
      check("cnt_cleared", 64'(b_drop_cnt), 64'd0);
`endif
      // Legal word still routes on the highest channel
      b_in_valid = 1; b_in_data = 16'h0A05; b_in_sel = 3'd5;
      cyc();
      b_in_valid = 0;
      @(negedge clk);
      check("b_legal_valid", 64'(b_out_valid), 64'h20);
      check("b_legal_data", 64'(b_out_data), 64'h0A05);
      cyc();

`ifdef DMUX_STREAM_CNT_EN
      // Saturation of the drop counter
      b_in_valid = 1; b_in_sel = 3'd7;
      repeat (300) cyc();
      b_in_valid = 0;
      @(negedge clk);
      check("cnt_sat", 64'(b_drop_cnt), 64'd255);
      cyc();
      b_err_clr = 1;
      cyc();
      b_err_clr = 0;
      @(negedge clk);
      check("cnt_sat_clr", 64'(b_drop_cnt), 64'd0);
      cyc();
`endif

      // Random valid/ready traffic on the 1-bit, 3-channel instance
      for (int i = 0; i < 600; i++) begin
         c_in_valid  = 1'($urandom_range(0, 1));
         c_in_data   = 1'($urandom_range(0, 1));
         c_in_sel    = 2'($urandom_range(0, 3));
         c_out_ready = 3'($urandom_range(0, 7));
         c_err_clr   = ($urandom_range(0, 15) == 0);
         cyc();
      end
      c_in_valid = 0; c_out_ready = 3'b111; c_err_clr = 0;
      repeat (4) cyc();
      b_out_ready = 6'h3F;
      repeat (2) cyc();

      check("a_drained", 64'(q_a.size()), 64'd0);
      check("b_drained", 64'(q_b.size()), 64'd0);
      check("c_drained", 64'(q_c.size()), 64'd0);
      check("c_idle_valid", 64'(c_out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
